// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: sizing, FSM state
// encoding and the big-endian byte-lane order used by the serializer.
package imem_loader_pkg;

  localparam int DEPTH          = 64;
  localparam int AW             = $clog2(DEPTH);
  localparam int CW             = 5;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  // Lane 3 (bits 31:24) goes to the lowest address, so the fetch side
  // finds op/rs at byte A and the immediate low byte at A+3.
  localparam int FIRST_LANE = 3;

  localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: load request, instruction word stream and byte write port.
// The csum signal exists only when IMEM_LOADER_CSUM_EN is defined.
interface imem_loader_if #(
  parameter int AW = imem_loader_pkg::AW,
  parameter int CW = imem_loader_pkg::CW
) ();

  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] word_count;
  logic          in_valid;
  logic [31:0]   in_word;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          busy;
  logic          done;
  logic          err;
`ifdef IMEM_LOADER_CSUM_EN
  logic [15:0]   csum;

  modport master (
    output start, base_addr, word_count, in_valid, in_word,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, csum
  );

  modport slave (
    input  start, base_addr, word_count, in_valid, in_word,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, csum
  );
`else
  modport master (
    output start, base_addr, word_count, in_valid, in_word,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );

  modport slave (
    input  start, base_addr, word_count, in_valid, in_word,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
  );
`endif

endinterface

// File: rtl/imem_loader_ser.sv
// 32-to-8 serializer: loads a word, then presents it one byte per shift,
// most significant byte first, with a 2-bit index of the byte on the output.
module imem_loader_ser
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        shift,
  input  logic [31:0] word,
  output logic [7:0]  lane_data,
  output logic [1:0]  byte_idx
);

  logic [31:0] shift_q;
  logic [1:0]  idx_q;

  // NOTE: the shift register is reset because its top byte drives mem_wdata
  // directly, and the write data bus must come out of reset at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (load) begin
      shift_q <= word;
      idx_q   <= '0;
    end else if (shift) begin
      shift_q <= {shift_q[23:0], 8'h00};
      idx_q   <= idx_q + 2'd1;
    end
  end

  assign lane_data = shift_q[FIRST_LANE*8 +: 8];
  assign byte_idx  = idx_q;

endmodule

// File: rtl/imem_loader.sv
// Program loader: accepts 32-bit words and writes them big-endian as four
// byte writes. Optional csum output enabled by IMEM_LOADER_CSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  imem_loader_if.slave bus
);

  localparam int EW = AW + CW + 1;

  state_t        state;
  logic [AW-1:0] addr;
  logic [CW-1:0] remaining;
  logic          in_ready_q;
  logic          mem_we_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic          ser_load;
  logic          ser_shift;
  logic [7:0]    ser_byte;
  logic [1:0]    byte_idx;

  logic [EW-1:0] end_addr;
  logic          start_ok;
  logic          last_byte;
  logic          last_word;

  // Computed wide enough that base + 4*count can never wrap.
  assign end_addr  = EW'(bus.base_addr) + EW'({bus.word_count, 2'b00});
  assign start_ok  = (bus.base_addr[1:0] == 2'b00) && (end_addr <= EW'(DEPTH));
  assign last_byte = (byte_idx == LAST_BYTE_IDX);
  assign last_word = (remaining == CW'(1));

  assign ser_load  = (state == WAIT) && bus.in_valid;
  assign ser_shift = (state == WRITE);

  imem_loader_ser u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .shift     (ser_shift),
    .word      (bus.in_word),
    .lane_data (ser_byte),
    .byte_idx  (byte_idx)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every branch sees the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (!start_ok) begin
              err_q <= 1'b1;
            end else if (bus.word_count == '0) begin
              state  <= FIN;
              busy_q <= 1'b1;
              done_q <= 1'b1;
            end else begin
              addr       <= bus.base_addr;
              remaining  <= bus.word_count;
              state      <= WAIT;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (bus.in_valid) begin
            state      <= WRITE;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b1;
          end
        end
        WRITE: begin
          if (last_byte) begin
            remaining <= remaining - CW'(1);
            mem_we_q  <= 1'b0;
            if (last_word) begin
              state  <= FIN;
              done_q <= 1'b1;
            end else begin
              state      <= WAIT;
              in_ready_q <= 1'b1;
              addr       <= addr + AW'(1);
            end
          end else begin
            addr <= addr + AW'(1);
          end
        end
        FIN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = ser_byte;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

`ifdef IMEM_LOADER_CSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if ((state == IDLE) && bus.start && start_ok) begin
      csum_q <= '0;
    end else if (state == WRITE) begin
      csum_q <= csum_q + 16'(ser_byte);
    end
  end

  assign bus.csum = csum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected byte writes are queued as
// words are driven and compared as the loader emits them.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  imem_loader_if bus ();

  imem_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           mon_e;
  int            n_checks  = 0;
  int            n_fail    = 0;
  int            cyc       = 0;
  int            done_seen = 0;
  logic [AW-1:0] exp_addr  = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.mem_we === 1'b1) begin
      check("in_ready low while writing", 32'(bus.in_ready), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected write addr", 32'(bus.mem_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("write addr", 32'(bus.mem_addr), 32'(mon_e.addr));
        check("write data", 32'(bus.mem_wdata), 32'(mon_e.data));
      end
    end
    if (rst === 1'b0 && bus.done === 1'b1) done_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int base, input int cnt);
    bit rej;
    rej = (base % 4 != 0) || (base + 4 * cnt > DEPTH);
    bus.start      = 1'b1;
    bus.base_addr  = AW'(base);
    bus.word_count = CW'(cnt);
    tick();
    bus.start      = 1'b0;
    bus.base_addr  = AW'($urandom);
    bus.word_count = CW'($urandom);
    check("err after start", 32'(bus.err), 32'(rej));
    check("busy after start", 32'(bus.busy), 32'(!rej));
    if (!rej && cnt == 0) check("done after zero-length start", 32'(bus.done), 32'd1);
    else                  check("no done after start", 32'(bus.done), 32'd0);
    if (!rej) begin
      exp_addr = AW'(base);
`ifdef IMEM_LOADER_CSUM_EN
      check("csum cleared on start", 32'(bus.csum), 32'd0);
`endif
    end else begin
      tick();
      check("err is one cycle", 32'(bus.err), 32'd0);
      check("busy stays low after reject", 32'(bus.busy), 32'd0);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit toggle, output int acc_cyc);
    bit accepted;
    accepted = 1'b0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      exp_q.push_back(wr_t'{exp_addr, w[31-8*i -: 8]});
      exp_addr = exp_addr + AW'(1);
    end
    for (int t = 0; t < 40 && !accepted; t++) begin
      bus.in_valid = toggle ? ~bus.in_valid : 1'b1;
      bus.in_word  = bus.in_valid ? w : $urandom;
      accepted     = bus.in_ready && bus.in_valid;
      tick();
    end
    check("word accepted within budget", 32'(accepted), 32'd1);
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    bus.in_word  = $urandom;
  endtask

  task automatic finish_load();
    repeat (3) tick();
    check("final byte strobe", 32'(bus.mem_we), 32'd1);
    tick();
    check("done after final byte", 32'(bus.done), 32'd1);
    check("strobe off at done", 32'(bus.mem_we), 32'd0);
    check("busy during done", 32'(bus.busy), 32'd1);
    tick();
    check("done is one cycle", 32'(bus.done), 32'd0);
    check("idle after done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c1, c2, d0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    bus.in_valid   = 1'b0;
    bus.in_word    = '0;
    repeat (2) tick();
    check("reset in_ready", 32'(bus.in_ready), 32'd0);
    check("reset mem_we", 32'(bus.mem_we), 32'd0);
    check("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    check("reset mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    tick();

    // Two-word load at 0, with a stray start while waiting for data.
    start_load(0, 2);
    check("in_ready in wait", 32'(bus.in_ready), 32'd1);
    bus.start = 1'b1; bus.base_addr = AW'(3); bus.word_count = CW'(1);
    tick();
    bus.start = 1'b0;
    check("start ignored while busy: err", 32'(bus.err), 32'd0);
    check("start ignored while busy: in_ready", 32'(bus.in_ready), 32'd1);
    send_word(32'h0401_0008, 1'b0, c1);
    send_word(32'h8C22_000C, 1'b0, c2);
    check("cycles per word", 32'(c2 - c1), 32'd5);
    finish_load();

    // Misaligned base.
    start_load(2, 1);
    repeat (3) tick();

    // Upper bound: last word fits exactly, one more does not.
    start_load(60, 1);
    send_word($urandom, 1'b0, c1);
    finish_load();
    start_load(60, 2);

    // Zero-length load.
    d0 = done_seen;
    start_load(0, 0);
    tick();
    check("zero-length done is one cycle", 32'(bus.done), 32'd0);
    check("zero-length idle", 32'(bus.busy), 32'd0);
    check("zero-length single done", 32'(done_seen - d0), 32'd1);

    // in_valid toggling every cycle.
    start_load(8, 3);
    for (int i = 0; i < 3; i++) send_word($urandom, 1'b1, c1);
    finish_load();

    // Reset during the third byte of the first word.
    start_load(0, 2);
    send_word(32'hA1B2_C3D4, 1'b0, c1);
    repeat (2) tick();
    check("third byte on bus", 32'(bus.mem_addr), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    d0 = done_seen;
    check("abort in_ready", 32'(bus.in_ready), 32'd0);
    check("abort mem_we", 32'(bus.mem_we), 32'd0);
    check("abort mem_addr", 32'(bus.mem_addr), 32'd0);
    check("abort mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort err", 32'(bus.err), 32'd0);
    repeat (8) tick();
    check("no done after abort", 32'(done_seen), 32'(d0));

    // Checksum load (bytes still scoreboarded in the default build).
    start_load(16, 2);
    send_word(32'hFFFF_FFFF, 1'b0, c1);
    send_word(32'h0102_0304, 1'b0, c2);
    finish_load();
`ifdef IMEM_LOADER_CSUM_EN
    check("csum after load", 32'(bus.csum), 32'h0406);
`endif

    check("all expected writes seen", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
